// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block: FSM state encoding,
// access-type encodings for `we`, and the data word width.
package mem_responder_pkg;

  localparam int WORD_W = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus for mem_responder. The CPU is the master, the responder
// is the slave.
interface mem_responder_if;
  import mem_responder_pkg::*;

  // Handshake: a request is taken on a rising edge where req=1 and the slave
  // is idle (busy=0). req/we/addr/wdata are ignored while busy=1 and nothing
  // is queued. Completion is the single-cycle ack pulse; rdata/err belong to
  // that ack and rdata holds its value until the next ack.
  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: one synchronous write port and one
// registered read port. Contents are not touched by reset; only the read
// register is cleared.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WORD_W-1:0]        rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with programmable wait states (IDLE/WAIT/ACK).
// Optional macro MEM_RESPONDER_ALIGN_CHECK_EN flags misaligned accesses via err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  output state_t               state_dbg
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic              ack_q;
  logic              busy_q;
  logic              err_q;

  logic              enter_ack;
  logic              acc_we;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              misaligned;
  logic              wr_en;
  logic              rd_en;
  logic [AW-1:0]     word_idx;
  logic [WORD_W-1:0] rdata_w;
  logic              unused_addr_bits;

  // With zero wait states ACK is entered straight from IDLE, so the access
  // must come from the live bus rather than the capture registers.
  assign enter_ack = !reset &&
                     (((state == ST_IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd0)));

  assign acc_we    = (state == ST_IDLE) ? bus.we    : cap_we;
  assign acc_addr  = (state == ST_IDLE) ? bus.addr  : cap_addr;
  assign acc_wdata = (state == ST_IDLE) ? bus.wdata : cap_wdata;
  assign word_idx  = acc_addr[AW+1:2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned = (acc_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign unused_addr_bits = ^{acc_addr[WORD_W-1:AW+2], acc_addr[1:0]};

  assign wr_en = enter_ack && (acc_we == MEM_WRITE) && !misaligned;
  assign rd_en = enter_ack && (acc_we == MEM_READ)  && !misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            cap_we    <= bus.we;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            busy_q    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACK;
              ack_q <= 1'b1;
              err_q <= misaligned;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
            err_q <= misaligned;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  mem_responder_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (word_idx),
    .wr_data (acc_wdata),
    .rd_en   (rd_en),
    .rd_idx  (word_idx),
    .rd_data (rdata_w)
  );

  assign bus.rdata = rdata_w;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// each checked every cycle against a transaction-timing model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH = 64;
  localparam int SB_W  = 33;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst0, rst1;
  state_t st0, st1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(rst0), .bus(bus0), .state_dbg(st0)
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(rst1), .bus(bus1), .state_dbg(st1)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // A transaction accepted at edge N completes at edge N+W; the slave takes
  // the next request no earlier than edge N+W+2.
  int          cyc = 0;
  bit          pend     [2];
  int          pend_edge[2];
  int          idle_from[2];
  logic        p_we     [2];
  logic [31:0] p_addr   [2];
  logic [31:0] p_wdata  [2];
  logic [31:0] m_mem    [2][DEPTH];
  logic [31:0] e_rdata  [2];
  logic        e_ack    [2];
  logic        e_busy   [2];
  logic        e_err    [2];
  logic [SB_W-1:0] exp_q [$];
  logic [SB_W-1:0] exp_q1[$];
  bit          chk_en = 1'b0;

  task automatic model_step(input int d, input int w, input logic rst, input logic req,
                            input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit mis;
    int idx;
    if (rst) begin
      pend[d] = 1'b0; idle_from[d] = 0;
      e_ack[d] = 1'b0; e_busy[d] = 1'b0; e_err[d] = 1'b0; e_rdata[d] = '0;
      return;
    end
    e_ack[d] = 1'b0;
    if (!pend[d] && cyc >= idle_from[d] && req) begin
      pend[d] = 1'b1; pend_edge[d] = cyc;
      p_we[d] = we; p_addr[d] = addr; p_wdata[d] = wdata;
    end
    if (pend[d] && cyc == pend_edge[d] + w) begin
      mis = ALIGN_EN && (p_addr[d][1:0] != 2'b00);
      idx = int'((p_addr[d] >> 2) % DEPTH);
      if (!mis) begin
        if (p_we[d]) m_mem[d][idx] = p_wdata[d];
        else         e_rdata[d]    = m_mem[d][idx];
      end
      e_err[d] = mis;
      e_ack[d] = 1'b1;
      pend[d]  = 1'b0;
      idle_from[d] = cyc + 2;
      if (d == 0) exp_q.push_back({mis, e_rdata[d]});
      else        exp_q1.push_back({mis, e_rdata[d]});
    end
    e_busy[d] = pend[d] || e_ack[d];
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, 2, rst0, bus0.req, bus0.we, bus0.addr, bus0.wdata);
    model_step(1, 0, rst1, bus1.req, bus1.we, bus1.addr, bus1.wdata);
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (chk_en) begin
      chk("ack0",   bus0.ack,   e_ack[0]);
      chk("busy0",  bus0.busy,  e_busy[0]);
      chk("rdata0", bus0.rdata, e_rdata[0]);
      if (bus0.ack) begin
        if (exp_q.size() == 0) chk("sb0_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb0_err",   bus0.err,   e[32]);
          chk("sb0_rdata", bus0.rdata, e[31:0]);
        end
      end
      chk("ack1",   bus1.ack,   e_ack[1]);
      chk("busy1",  bus1.busy,  e_busy[1]);
      chk("rdata1", bus1.rdata, e_rdata[1]);
      if (bus1.ack) begin
        if (exp_q1.size() == 0) chk("sb1_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = exp_q1.pop_front();
          chk("sb1_err",   bus1.err,   e[32]);
          chk("sb1_rdata", bus1.rdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wait_idle0();
    int guard = 0;
    while (bus0.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_idle0", bus0.busy, 1'b0);
  endtask

  task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output int bcnt, output logic [31:0] rd, output logic er);
    bit ok = 1'b0;
    wait_idle0();
    bus0.req = 1'b1; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata;
    @(negedge clk);
    lat = 1; bcnt = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus0.busy) bcnt++;
      if (bus0.ack) begin
        rd = bus0.rdata; er = bus0.err; ok = 1'b1;
        break;
      end
      bus0.req   = 1'($urandom_range(0, 1));
      bus0.we    = 1'($urandom_range(0, 1));
      bus0.addr  = $urandom;
      bus0.wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    bus0.req = 1'b0;
    chk("txn0_ack_seen", ok, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bc, n_ack, last, ti;
    logic [31:0] rd, w_addr, w_data;
    logic er;

    rst0 = 1'b1; rst1 = 1'b1;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy",  bus0.busy,  1'b0);
    chk("reset_ack",   bus0.ack,   1'b0);
    chk("reset_err",   bus0.err,   1'b0);
    chk("reset_rdata", bus0.rdata, 32'h0);

    // request presented while reset is held must be dropped
    bus0.req = 1'b1; bus0.we = MEM_WRITE; bus0.addr = 32'h10; bus0.wdata = 32'h77;
    @(negedge clk);
    chk("reset_with_req_busy", bus0.busy, 1'b0);
    bus0.req = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", bus0.busy, 1'b0);

    for (int i = 0; i < DEPTH; i++) txn0(MEM_WRITE, 32'(i * 4), $urandom, lat, bc, rd, er);

    // write then read-back, with latency and busy span
    txn0(MEM_WRITE, 32'h10, 32'hDEADBEEF, lat, bc, rd, er);
    chk("wr_latency", lat, 3);
    chk("wr_busy_cycles", bc, 3);
    chk("wr_err", er, 1'b0);
    txn0(MEM_READ, 32'h10, 32'h0, lat, bc, rd, er);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);
    chk("rd_err", er, 1'b0);

    // address wrap modulo DEPTH*4
    txn0(MEM_WRITE, 32'h100, 32'h5, lat, bc, rd, er);
    txn0(MEM_READ, 32'h000, 32'h0, lat, bc, rd, er);
    chk("wrap_read", rd, 32'h5);

    // reset during WAIT aborts a write
    txn0(MEM_WRITE, 32'h20, 32'hAAAA5555, lat, bc, rd, er);
    wait_idle0();
    bus0.req = 1'b1; bus0.we = MEM_WRITE; bus0.addr = 32'h20; bus0.wdata = 32'h1234;
    @(negedge clk);
    chk("abort_in_wait", bus0.busy, 1'b1);
    rst0 = 1'b1; bus0.req = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    chk("abort_busy_clear", bus0.busy, 1'b0);
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.ack) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    txn0(MEM_READ, 32'h20, 32'h0, lat, bc, rd, er);
    chk("abort_prior_value", rd, 32'hAAAA5555);

    // misaligned write
    txn0(MEM_WRITE, 32'h13, 32'hCAFEF00D, lat, bc, rd, er);
    chk("misalign_err", er, ALIGN_EN);
    txn0(MEM_READ, 32'h10, 32'h0, lat, bc, rd, er);
    chk("misalign_word", rd, ALIGN_EN ? 32'hDEADBEEF : 32'hCAFEF00D);

    // randomized traffic, including misaligned and wrapping addresses
    for (int i = 0; i < 150; i++) begin
      txn0(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)), $urandom, lat, bc, rd, er);
      chk("rand_latency", lat, 3);
    end

    // zero-wait instance: req held high, alternating write/read, noise while busy
    n_ack = 0; last = -1; ti = 0; w_addr = '0; w_data = '0;
    for (int c = 0; c < 40; c++) begin
      if (!bus1.busy) begin
        bus1.req = 1'b1;
        if (ti % 2 == 0) begin
          w_addr = {22'($urandom_range(0, 255)), 2'b00} + 32'($urandom_range(0, 1) * 1024);
          w_data = $urandom;
          bus1.we = MEM_WRITE; bus1.addr = w_addr; bus1.wdata = w_data;
        end else begin
          bus1.we = MEM_READ; bus1.addr = w_addr; bus1.wdata = $urandom;
        end
        ti++;
      end else begin
        bus1.req   = 1'($urandom_range(0, 1));
        bus1.we    = 1'($urandom_range(0, 1));
        bus1.addr  = $urandom;
        bus1.wdata = $urandom;
      end
      @(negedge clk);
      if (bus1.ack) begin
        n_ack++;
        if (last >= 0) chk("w0_ack_gap", c - last, 2);
        last = c;
        if (ti % 2 == 0) chk("w0_read_after_write", bus1.rdata, w_data);
      end
    end
    bus1.req = 1'b0;
    chk("w0_ack_count", n_ack, 20);

    repeat (4) @(negedge clk);
    chk("sb0_drained", exp_q.size(), 0);
    chk("sb1_drained", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words held; power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between accepted request and ack; 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  CPU memory request strobe; sampled only in IDLE.
REQ-006 we  input  1  access type, driven from DataMemRW; 0 = read, 1 = write.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data; valid in the ack cycle, held until the next ack.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 err  output  1  access error flag; meaningful only with ack.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and ACK.
REQ-014 IDLE with req=1: capture addr, we, wdata; go to WAIT if WAIT_CYCLES>0, else go directly to ACK.
REQ-015 WAIT: a 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0 go to ACK.
REQ-016 ACK: ack=1 for exactly one cycle, then IDLE unconditionally.
REQ-017 Latency: req sampled at edge N SHALL give ack high in cycle N+1+WAIT_CYCLES.
REQ-018 Word index = captured addr[log2(DEPTH)+1:2]; higher address bits ignored, so addresses wrap modulo DEPTH*4.
REQ-019 Write: the array is updated at the same edge that enters ACK; rdata is unchanged on writes.
REQ-020 Read: rdata loads the array word at the edge entering ACK.
REQ-021 req, we, addr and wdata SHALL be ignored in WAIT and ACK; no queuing.
REQ-022 req held high continuously SHALL give back-to-back transactions, one per 2+WAIT_CYCLES cycles.
REQ-023 Read after write to the same word in consecutive transactions SHALL return the new data.

Reset
REQ-024 reset SHALL force IDLE, counter=0, ack=0, busy=0, err=0 and rdata=0.
REQ-025 reset during WAIT SHALL abort the transaction with no array write and no ack.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 reset asserted together with req SHALL accept no request in that cycle.

Configuration
REQ-028 Macro MEM_RESPONDER_ALIGN_CHECK_EN defined:
- captured addr[1:0]!=0 completes with normal latency and ack=1, err=1;
- no array write occurs and rdata is unchanged.
REQ-029 Macro undefined:
- addr[1:0] is ignored and err is tied to 0.

Structure
REQ-030 Package mem_responder_pkg SHALL hold:
- the FSM state enum;
- MEM_READ/MEM_WRITE encodings for we;
- the word width constant of 32.
REQ-031 Storage SHALL be a sub-module mem_responder_array:
- ports: one synchronous write port and one registered read port;
- the FSM drives its write enable only on the edge entering ACK.

Verification
REQ-032 Reset, then write 0xDEADBEEF to addr 0x10 -> ack in cycle 3 after req sample (WAIT_CYCLES=2), busy high for 3 cycles.
REQ-033 Read addr 0x10 right after REQ-032 -> rdata=0xDEADBEEF with ack, err=0.
REQ-034 DEPTH=64, write 0x5 to addr 0x100 -> read of addr 0x000 returns 0x5 (wrap).
REQ-035 reset pulsed during WAIT of a write of 0x1234 to 0x20 -> no ack; a later read of 0x20 returns the prior value.
REQ-036 MEM_RESPONDER_ALIGN_CHECK_EN defined, write to addr 0x13 -> ack=1, err=1, word 0x10 unchanged; macro undefined, same write -> err=0, word 0x10 written.
REQ-037 WAIT_CYCLES=0, req held high alternating write/read -> ack every 2nd cycle; req toggled during busy has no effect.
